// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types for the pipeline control unit
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, ACK} pctrl_state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that holds at all-ones
module sat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);
  logic [WIDTH-1:0] cnt_d, cnt_q;
  // clear has priority; increment stops once every bit is set
  always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != '1) ? cnt_q + WIDTH'(1) : cnt_q;
  // count register
  always_ff @(posedge clk_i) cnt_q <= !rst_ni ? '0 : cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_ctrl_unit.sv
// pipeline_ctrl_unit: merges stage stall/flush requests and sequences drain-then-flush
module pipeline_ctrl_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int NUM_STAGES    = 4,
  parameter int FLUSH_CYCLES  = 1,
  parameter int DRAIN_TIMEOUT = 64,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_STAGES-1:0] stall_req_i,
  input  logic [NUM_STAGES-1:0] flush_req_i,
  input  logic [NUM_STAGES-1:0] stage_valid_i,
  input  logic                  drain_req_i,
  output logic [NUM_STAGES-1:0] m_ctrl_stall,
  output logic [NUM_STAGES-1:0] m_ctrl_flush,
  output logic                  in_gate_o,
  output logic                  drain_ack_o,
  output logic                  drain_timeout_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [TW-1:0] DT_LAST = TW'(DRAIN_TIMEOUT - 1);
  localparam logic [FW-1:0] FL_LAST = FW'(FLUSH_CYCLES - 1);

  pctrl_state_e state_d, state_q;
  logic drain_to_d, drain_to_q;
  logic fsm_flush;
  logic [TW-1:0] drain_tmr;
  logic [FW-1:0] flush_tmr;
  logic [NUM_STAGES-1:0] stall_or, flush_or;

  // a request at stage j affects stage j and everything upstream of it
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_pfx
    assign stall_or[i] = |stall_req_i[NUM_STAGES-1:i];
    assign flush_or[i] = |flush_req_i[NUM_STAGES-1:i];
  end

  assign m_ctrl_flush = flush_or | {NUM_STAGES{fsm_flush}};
  assign m_ctrl_stall = stall_or & ~m_ctrl_flush;

  sat_counter #(.WIDTH(TW)) u_drain_tmr (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .en_i(state_q == DRAIN), .clr_i(state_q != DRAIN), .cnt_o(drain_tmr)
  );

  sat_counter #(.WIDTH(FW)) u_flush_tmr (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .en_i(state_q == FLUSH), .clr_i(state_q != FLUSH), .cnt_o(flush_tmr)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .en_i(|m_ctrl_stall), .clr_i(1'b0), .cnt_o(stall_cnt_o)
  );

  // state and sticky timeout registers
  always_ff @(posedge clk_i) begin
    state_q    <= !rst_ni ? IDLE : state_d;
    drain_to_q <= !rst_ni ? 1'b0 : drain_to_d;
  end

  // next state; an empty pipe beats the timeout so timeout only flags a real stuck drain
  always_comb begin
    state_d    = state_q;
    drain_to_d = drain_to_q;
    case (state_q)
      IDLE: if (drain_req_i) begin
        state_d    = DRAIN;
        drain_to_d = 1'b0;
      end
      DRAIN: if (stage_valid_i == '0) state_d = FLUSH;
        else if (drain_tmr == DT_LAST) begin
          state_d    = FLUSH;
          drain_to_d = 1'b1;
        end
      FLUSH: if (flush_tmr == FL_LAST) state_d = ACK;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    in_gate_o   = state_q == IDLE;
    busy_o      = state_q != IDLE;
    fsm_flush   = state_q == FLUSH;
    drain_ack_o = state_q == ACK;
  end

  assign drain_timeout_o = drain_to_q;
endmodule
